enc_rr_arbiter: RTL and testbench

Round-robin arbiter that shares a single encoder datapath among N requesters. It picks one pending requester, encodes its position into a binary index, and holds the grant until the owner finishes or a hold timeout forces release. It sits in front of the encoder-based select/mux logic, so `grant_idx` can drive a shared resource's select input directly.

---
 rtl/enc_rr_arbiter.sv | 113 +++++++++++
 tb/tb_enc_rr_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/enc_rr_arbiter.sv
// Round-robin arbiter sharing one encoder datapath among N requesters.
// Grants one requester at a time, reports its binary index, and bounds hold time.
module enc_rr_arbiter #(
  parameter int N        = 4,
  parameter int IDX_W    = 2,
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             timeout
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, state_nx;
  logic [IDX_W-1:0]  ptr, ptr_nx;
  logic [HOLD_W-1:0] hold_cnt, hold_nx;
  logic [N-1:0]      grant_nx;
  logic [IDX_W-1:0]  idx_nx;
  logic              valid_nx;
  logic              timeout_nx;

  logic [IDX_W-1:0]  pick_idx;
  logic              pick_found;
  int                cand;
  logic [IDX_W-1:0]  ptr_after_owner;
  logic              hold_expired;

  // Circular priority search: first set request at or after ptr, wrapping to 0.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int off = 0; off < N; off++) begin
      cand = int'(ptr) + off;
      if (cand >= N) cand = cand - N;
      if (!pick_found && req[IDX_W'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  assign ptr_after_owner = (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);
  assign hold_expired    = (MAX_HOLD != 0) && (hold_cnt == HOLD_W'(MAX_HOLD - 1));

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    state_nx   = state;
    ptr_nx     = ptr;
    hold_nx    = hold_cnt;
    grant_nx   = '0;
    idx_nx     = '0;
    valid_nx   = 1'b0;
    timeout_nx = 1'b0;

    unique case (state)
      IDLE: begin
        if (pick_found) begin
          state_nx = BUSY;
          grant_nx = {{(N-1){1'b0}}, 1'b1} << pick_idx;
          idx_nx   = pick_idx;
          valid_nx = 1'b1;
          hold_nx  = '0;
        end
      end
      BUSY: begin
        if (done || !req[grant_idx] || hold_expired) begin
          // done takes precedence, so a simultaneous timeout reads as a normal release
          state_nx   = IDLE;
          ptr_nx     = ptr_after_owner;
          timeout_nx = !done && req[grant_idx] && hold_expired;
        end else begin
          hold_nx  = hold_cnt + HOLD_W'(1);
          grant_nx = grant;
          idx_nx   = grant_idx;
          valid_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values and simulation matches the synthesized hardware.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      hold_cnt    <= '0;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_nx;
      ptr         <= ptr_nx;
      hold_cnt    <= hold_nx;
      grant       <= grant_nx;
      grant_idx   <= idx_nx;
      grant_valid <= valid_nx;
      timeout     <= timeout_nx;
    end
  end

endmodule

// File: tb/tb_enc_rr_arbiter.sv
// Scoreboard bench for enc_rr_arbiter: directed vectors push hand-computed
// expected outputs; a monitor pops and compares one entry per clock edge.
module tb_enc_rr_arbiter;

  localparam int N = 4, IDX_W = 2, MAX_HOLD = 16, HOLD_W = 8;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     req;
  logic             done;
  logic [N-1:0]     grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;
  logic             timeout;

  typedef struct packed {
    logic [N-1:0]     grant;
    logic [IDX_W-1:0] idx;
    logic             valid;
    logic             timeout;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    errors = 0;
  int    checks = 0;

  enc_rr_arbiter #(.N(N), .IDX_W(IDX_W), .MAX_HOLD(MAX_HOLD), .HOLD_W(HOLD_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .grant(grant), .grant_idx(grant_idx), .grant_valid(grant_valid), .timeout(timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input exp_t act, input exp_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got grant=%b idx=%0d valid=%b timeout=%b, want grant=%b idx=%0d valid=%b timeout=%b",
               nm, act.grant, act.idx, act.valid, act.timeout,
               exp.grant, exp.idx, exp.valid, exp.timeout);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input logic r, input logic [N-1:0] rq, input logic d,
                      input logic ev, input logic [IDX_W-1:0] ei, input logic et,
                      input string nm);
    exp_t e;
    @(negedge clk);
    rst_n = r;
    req   = rq;
    done  = d;
    e.grant   = ev ? (N'(1) << ei) : '0;
    e.idx     = ev ? ei : '0;
    e.valid   = ev;
    e.timeout = et;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: sample 1 time unit after each rising edge.
  always @(posedge clk) begin
    exp_t  e;
    exp_t  a;
    string nm;
    #1;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = '{grant: grant, idx: grant_idx, valid: grant_valid, timeout: timeout};
      check(nm, a, e);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time=%0t, want < 200000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [IDX_W-1:0] rot [5];
    rot[0] = 2'd0; rot[1] = 2'd1; rot[2] = 2'd2; rot[3] = 2'd3; rot[4] = 2'd0;
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;

    // 1. Reset (req ignored while in reset) and single requester
    step(0, 4'b0100, 0, 0, 0, 0, "reset_0");
    step(0, 4'b0100, 0, 0, 0, 0, "reset_1");
    step(1, 4'b0100, 0, 1, 2, 0, "single_grant");
    step(1, 4'b0100, 0, 1, 2, 0, "single_hold");
    step(1, 4'b0100, 1, 0, 0, 0, "single_done");
    step(1, 4'b0100, 0, 1, 2, 0, "single_regrant");
    step(1, 4'b0100, 1, 0, 0, 0, "single_done2");
    step(1, 4'b0000, 0, 0, 0, 0, "idle_no_req");

    // 2. Rotation from ptr=0 with all requesting, done every 3rd cycle
    step(0, 4'b1111, 0, 0, 0, 0, "reset_rot");
    for (int i = 0; i < 5; i++) begin
      step(1, 4'b1111, 0, 1, rot[i], 0, $sformatf("rot%0d_grant", i));
      step(1, 4'b1111, 0, 1, rot[i], 0, $sformatf("rot%0d_hold", i));
      step(1, 4'b1111, 1, 0, 0, 0, $sformatf("rot%0d_bubble", i));
    end

    // 3. Wrap and skip: ptr=1, grant 3, then 0101 gives 0,2,0
    step(1, 4'b1000, 0, 1, 3, 0, "wrap_grant3");
    step(1, 4'b0101, 1, 0, 0, 0, "wrap_rel3");
    step(1, 4'b0101, 0, 1, 0, 0, "wrap_grant0");
    step(1, 4'b0101, 1, 0, 0, 0, "wrap_rel0");
    step(1, 4'b0101, 0, 1, 2, 0, "skip_grant2");
    step(1, 4'b0101, 1, 0, 0, 0, "skip_rel2");
    step(1, 4'b0101, 0, 1, 0, 0, "wrap_grant0b");
    step(1, 4'b0101, 1, 0, 0, 0, "wrap_rel0b");

    // 4. Timeout: 16 grant cycles then a one-cycle pulse; ptr=1 here
    step(1, 4'b0010, 0, 1, 1, 0, "to_grant");
    for (int i = 0; i < MAX_HOLD - 1; i++)
      step(1, 4'b0010, 0, 1, 1, 0, $sformatf("to_hold%0d", i));
    step(1, 4'b0010, 0, 0, 0, 1, "to_pulse");
    step(1, 4'b0010, 0, 1, 1, 0, "to_regrant");
    for (int i = 0; i < MAX_HOLD - 1; i++)
      step(1, 4'b0010, 0, 1, 1, 0, $sformatf("to2_hold%0d", i));
    step(1, 4'b0010, 1, 0, 0, 0, "done_at_limit_no_timeout");
    step(1, 4'b0000, 0, 0, 0, 0, "to_idle");

    // 5. Owner withdrawal: ptr=2, grant 1, drop req[1] with req[3] high
    step(1, 4'b0010, 0, 1, 1, 0, "wd_grant1");
    step(1, 4'b1000, 0, 0, 0, 0, "wd_release");
    step(1, 4'b1000, 0, 1, 3, 0, "wd_grant3");
    step(1, 4'b1000, 1, 0, 0, 0, "wd_rel3");

    // 6. Reset mid-grant (index 2, hold_cnt=5), then first grant is index 0
    step(1, 4'b0100, 0, 1, 2, 0, "mr_grant2");
    for (int i = 0; i < 5; i++)
      step(1, 4'b0100, 0, 1, 2, 0, $sformatf("mr_hold%0d", i));
    step(0, 4'b1111, 0, 0, 0, 0, "mr_reset");
    step(1, 4'b1111, 0, 1, 0, 0, "mr_first_grant0");
    step(1, 4'b1111, 1, 0, 0, 0, "mr_rel0");

    // Drain the scoreboard within a bounded number of edges
    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
